wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/defines.v | 9 +
 rtl/rr_arb2.sv | 43 ++++
 rtl/wb_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared types for the write-back arbiter.
//   prio_e   - round-robin priority pointer (which requester is preferred on contention).
//   wb_req_t - index/data pair of one write-back request.
//   NumRegs  - architectural register count, derived from the shared index width.
`include "defines.v"

package wb_arbiter_pkg;

  localparam int unsigned NumRegs = 1 << `REG_IDX_WIDTH;

  typedef enum logic {
    PrioEx = 1'b0,
    PrioLs = 1'b1
  } prio_e;

  typedef struct packed {
    logic [`REG_IDX_WIDTH-1:0] idx;
    logic [`XLEN-1:0]          data;
  } wb_req_t;

endpackage

// File: rtl/defines.v
// Shared core-wide constants: data width, register index width and the x0 index.
`ifndef WB_DEFINES_V
`define WB_DEFINES_V

`define XLEN          32
`define REG_IDX_WIDTH 5
`define REG_X0        5'd0

`endif

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with a registered priority pointer.
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   req_ex_i, req_ls_i   - requests from execute and load/store units
//   gnt_ex_o, gnt_ls_o   - combinational one-hot (or zero) grants
// The pointer moves away from whichever requester was just granted; a grant is always
// a completed handshake because it is only raised while the request is valid.
`include "defines.v"

module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_ex_i,
  input  logic req_ls_i,
  output logic gnt_ex_o,
  output logic gnt_ls_o
);

  prio_e prio_q, prio_d;

  always_comb begin
    gnt_ex_o = req_ex_i & (~req_ls_i | (prio_q == PrioEx));
    gnt_ls_o = req_ls_i & (~req_ex_i | (prio_q == PrioLs));
    prio_d   = prio_q;
    if (gnt_ex_o) begin
      prio_d = PrioLs;
    end else if (gnt_ls_o) begin
      prio_d = PrioEx;
    end
  end

  // Reset dominates, so a handshake in the reset cycle never moves the pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= PrioEx;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: arbitrates execute and load/store write-backs onto one regfile write port,
// with a one-cycle registered output stage and an optional register scoreboard.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   ex_valid_i/ex_ready_o/ex_rd_idx_i/ex_wdata_i - execute write-back request
//   ls_valid_i/ls_ready_o/ls_rd_idx_i/ls_wdata_i - load/store write-back request
//   rd_en_o, rd_idx_o, rd_wdata_o     - registered regfile write port
//   iss_en_i, iss_rd_idx_i, flush_i   - scoreboard set / clear-all
//   rs1_idx_i, rs2_idx_i              - decode source indices
//   rs1_busy_o, rs2_busy_o            - source has a pending write
// Configuration: define WB_ARB_SCOREBOARD_EN to build the scoreboard; otherwise the busy
// outputs are tied low and the issue/flush inputs are ignored.
`include "defines.v"

module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid_i,
  output logic                      ex_ready_o,
  input  logic [`REG_IDX_WIDTH-1:0] ex_rd_idx_i,
  input  logic [`XLEN-1:0]          ex_wdata_i,
  input  logic                      ls_valid_i,
  output logic                      ls_ready_o,
  input  logic [`REG_IDX_WIDTH-1:0] ls_rd_idx_i,
  input  logic [`XLEN-1:0]          ls_wdata_i,
  output logic                      rd_en_o,
  output logic [`REG_IDX_WIDTH-1:0] rd_idx_o,
  output logic [`XLEN-1:0]          rd_wdata_o,
  input  logic                      iss_en_i,
  input  logic [`REG_IDX_WIDTH-1:0] iss_rd_idx_i,
  input  logic                      flush_i,
  input  logic [`REG_IDX_WIDTH-1:0] rs1_idx_i,
  input  logic [`REG_IDX_WIDTH-1:0] rs2_idx_i,
  output logic                      rs1_busy_o,
  output logic                      rs2_busy_o
);

  logic ex_gnt, ls_gnt;

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_ex_i (ex_valid_i),
    .req_ls_i (ls_valid_i),
    .gnt_ex_o (ex_gnt),
    .gnt_ls_o (ls_gnt)
  );

  assign ex_ready_o = ex_gnt;
  assign ls_ready_o = ls_gnt;

  // Output stage.
  wb_req_t                   sel;
  logic                      hs;
  logic                      rd_en_q, rd_en_d;
  logic [`REG_IDX_WIDTH-1:0] rd_idx_q, rd_idx_d;
  logic [`XLEN-1:0]          rd_wdata_q, rd_wdata_d;

  always_comb begin
    sel        = ls_gnt ? wb_req_t'{idx: ls_rd_idx_i, data: ls_wdata_i}
                        : wb_req_t'{idx: ex_rd_idx_i, data: ex_wdata_i};
    hs         = ex_gnt | ls_gnt;
    // An x0 write still handshakes but never reaches the regfile.
    rd_en_d    = hs & (sel.idx != `REG_X0);
    rd_idx_d   = hs ? sel.idx  : rd_idx_q;
    rd_wdata_d = hs ? sel.data : rd_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_en_q    <= 1'b0;
      rd_idx_q   <= '0;
      rd_wdata_q <= '0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_idx_q   <= rd_idx_d;
      rd_wdata_q <= rd_wdata_d;
    end
  end

  assign rd_en_o    = rd_en_q;
  assign rd_idx_o   = rd_idx_q;
  assign rd_wdata_o = rd_wdata_q;

`ifdef WB_ARB_SCOREBOARD_EN
  // Pending bits for x1..x(NumRegs-1); x0 has no storage.
  logic [NumRegs-1:1] pend_q, pend_d;
  logic [NumRegs-1:0] pend_full;

  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 1; i < NumRegs; i++) begin
      if (rd_en_q && (rd_idx_q == i[`REG_IDX_WIDTH-1:0])) begin
        pend_d[i] = 1'b0;
      end
      // Applied after the clear so a same-index set wins.
      if (iss_en_i && (iss_rd_idx_i == i[`REG_IDX_WIDTH-1:0])) begin
        pend_d[i] = 1'b1;
      end
    end
    if (flush_i) begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Bit 0 is hard-wired low so index 0 always reads not-busy.
  assign pend_full  = {pend_q, 1'b0};
  assign rs1_busy_o = pend_full[rs1_idx_i];
  assign rs2_busy_o = pend_full[rs2_idx_i];
`else
  logic unused_sb;
  assign unused_sb  = ^{iss_en_i, iss_rd_idx_i, flush_i, rs1_idx_i, rs2_idx_i};
  assign rs1_busy_o = 1'b0;
  assign rs2_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed bench for wb_arbiter. A behavioural model (last-granted flag,
// pending array, expected output registers) is checked against the DUT on every falling
// edge; directed scenarios add literal expectations that pin the model.
module tb_wb_arbiter;

  localparam int IW = 5;
  localparam int XW = 32;
`ifdef WB_ARB_SCOREBOARD_EN
  localparam bit Sb = 1'b1;
`else
  localparam bit Sb = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ex_valid = 1'b0, ls_valid = 1'b0;
  logic          ex_ready, ls_ready;
  logic [IW-1:0] ex_rd = '0, ls_rd = '0;
  logic [XW-1:0] ex_data = '0, ls_data = '0;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic [XW-1:0] rd_wdata;
  logic          iss_en = 1'b0, flush = 1'b0;
  logic [IW-1:0] iss_rd = '0, rs1 = '0, rs2 = '0;
  logic          rs1_busy, rs2_busy;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid),
    .ex_ready_o   (ex_ready),
    .ex_rd_idx_i  (ex_rd),
    .ex_wdata_i   (ex_data),
    .ls_valid_i   (ls_valid),
    .ls_ready_o   (ls_ready),
    .ls_rd_idx_i  (ls_rd),
    .ls_wdata_i   (ls_data),
    .rd_en_o      (rd_en),
    .rd_idx_o     (rd_idx),
    .rd_wdata_o   (rd_wdata),
    .iss_en_i     (iss_en),
    .iss_rd_idx_i (iss_rd),
    .flush_i      (flush),
    .rs1_idx_i    (rs1),
    .rs2_idx_i    (rs2),
    .rs1_busy_o   (rs1_busy),
    .rs2_busy_o   (rs2_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state.
  bit            m_live = 1'b0;
  bit            m_last_ex = 1'b0;
  bit            m_en = 1'b0;
  bit            m_dc = 1'b0;
  logic [IW-1:0] m_idx = '0;
  logic [XW-1:0] m_data = '0;
  bit            m_pend [32];

  function automatic void model_grant(output bit gex, output bit gls);
    gex = 1'b0;
    gls = 1'b0;
    if (ex_valid && ls_valid) begin
      if (m_last_ex) gls = 1'b1;
      else gex = 1'b1;
    end else if (ex_valid) begin
      gex = 1'b1;
    end else if (ls_valid) begin
      gls = 1'b1;
    end
  endfunction

  bit u_gex, u_gls;
  always @(posedge clk) begin
    model_grant(u_gex, u_gls);
    if (rst) begin
      m_live    = 1'b1;
      m_last_ex = 1'b0;
      m_en      = 1'b0;
      m_dc      = 1'b0;
      m_idx     = '0;
      m_data    = '0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else begin
      if (Sb) begin
        if (m_en) m_pend[m_idx] = 1'b0;
        if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
        if (flush) foreach (m_pend[i]) m_pend[i] = 1'b0;
      end
      if (u_gex || u_gls) begin
        m_idx     = u_gex ? ex_rd : ls_rd;
        m_data    = u_gex ? ex_data : ls_data;
        m_en      = (m_idx != 0);
        m_dc      = (m_idx == 0);
        m_last_ex = u_gex;
      end else begin
        m_en = 1'b0;
      end
    end
  end

  bit c_gex, c_gls;
  always @(negedge clk) begin
    if (m_live) begin
      model_grant(c_gex, c_gls);
      chk("m_ex_ready", ex_ready, c_gex);
      chk("m_ls_ready", ls_ready, c_gls);
      chk("m_rd_en", rd_en, m_en);
      if (!m_dc) begin
        chk("m_rd_idx", rd_idx, m_idx);
        chk("m_rd_wdata", rd_wdata, m_data);
      end
      chk("m_rs1_busy", rs1_busy, (rs1 != 0) && m_pend[rs1]);
      chk("m_rs2_busy", rs2_busy, (rs2 != 0) && m_pend[rs2]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    step();
    step();
    rst = 1'b0;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_rd_wdata", rd_wdata, 0);
    chk("rst_busy", rs1_busy, 0);

    // Single ex request.
    ex_valid = 1'b1; ex_rd = 5; ex_data = 32'hDEADBEEF;
    #1;
    chk("single_ex_ready", ex_ready, 1);
    chk("single_ls_ready", ls_ready, 0);
    step();
    ex_valid = 1'b0;
    chk("single_rd_en", rd_en, 1);
    chk("single_rd_idx", rd_idx, 5);
    chk("single_rd_wdata", rd_wdata, 32'hDEADBEEF);

    // Contention from reset: ex, ls, ex, ls.
    rst = 1'b1;
    step();
    rst = 1'b0;
    ex_valid = 1'b1; ex_rd = 3; ex_data = 32'h0000_0003;
    ls_valid = 1'b1; ls_rd = 4; ls_data = 32'h0000_0004;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ex_ready", ex_ready, (i % 2 == 0) ? 1 : 0);
      chk("cont_ls_ready", ls_ready, (i % 2 == 0) ? 0 : 1);
      step();
      chk("cont_rd_en", rd_en, 1);
      chk("cont_rd_idx", rd_idx, (i % 2 == 0) ? 3 : 4);
    end
    ex_valid = 1'b0;
    ls_valid = 1'b0;
    step();
    chk("cont_idle_rd_en", rd_en, 0);
    chk("cont_hold_idx", rd_idx, 4);

    // x0 write.
    ls_valid = 1'b1; ls_rd = 0; ls_data = 32'h1234;
    #1;
    chk("x0_ls_ready", ls_ready, 1);
    step();
    ls_valid = 1'b0;
    chk("x0_rd_en", rd_en, 0);

    // Scoreboard set then clear.
    iss_en = 1'b1; iss_rd = 7; rs1 = 7;
    step();
    iss_en = 1'b0;
    #1;
    chk("sb_set_busy", rs1_busy, Sb);
    ex_valid = 1'b1; ex_rd = 7; ex_data = 32'h7777;
    step();
    ex_valid = 1'b0;
    #1;
    chk("sb_wr_rd_en", rd_en, 1);
    chk("sb_wr_busy", rs1_busy, Sb);
    step();
    chk("sb_clr_busy", rs1_busy, 0);

    // Same-cycle set and clear on x9: set wins.
    rs2 = 9; iss_en = 1'b1; iss_rd = 9;
    step();
    iss_en = 1'b0;
    ex_valid = 1'b1; ex_rd = 9; ex_data = 32'h9999;
    step();
    ex_valid = 1'b0;
    iss_en = 1'b1; iss_rd = 9;
    #1;
    chk("sc_rd_idx", rd_idx, 9);
    step();
    iss_en = 1'b0;
    #1;
    chk("sc_busy", rs2_busy, Sb);

    // Same again with flush: everything clears, output stage still writes.
    rs1 = 12; iss_en = 1'b1; iss_rd = 12;
    step();
    iss_en = 1'b0;
    ex_valid = 1'b1; ex_rd = 9; ex_data = 32'h9998;
    step();
    ex_valid = 1'b0;
    iss_en = 1'b1; iss_rd = 9; flush = 1'b1;
    #1;
    chk("fl_pre_busy", rs1_busy, Sb);
    chk("fl_rd_en", rd_en, 1);
    step();
    iss_en = 1'b0; flush = 1'b0;
    #1;
    chk("fl_busy1", rs1_busy, 0);
    chk("fl_busy2", rs2_busy, 0);
    chk("fl_hold_data", rd_wdata, 32'h9998);

    // Reset mid-stream: ls is preferred, both valid, x7 pending.
    rs1 = 7; iss_en = 1'b1; iss_rd = 7;
    step();
    iss_en = 1'b0;
    ex_valid = 1'b1; ex_rd = 10; ex_data = 32'hA0A0_0010;
    ls_valid = 1'b1; ls_rd = 11; ls_data = 32'hB0B0_0011;
    rst = 1'b1;
    #1;
    chk("rm_ls_ready", ls_ready, 1);
    chk("rm_pre_busy", rs1_busy, Sb);
    step();
    rst = 1'b0;
    #1;
    chk("rm_rd_en", rd_en, 0);
    chk("rm_rd_idx", rd_idx, 0);
    chk("rm_rd_wdata", rd_wdata, 0);
    chk("rm_busy", rs1_busy, 0);
    chk("rm_ex_first", ex_ready, 1);
    step();
    ex_valid = 1'b0;
    chk("rm_wr_idx", rd_idx, 10);
    chk("rm_wr_data", rd_wdata, 32'hA0A0_0010);
    step();
    ls_valid = 1'b0;
    chk("rm_ls_idx", rd_idx, 11);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
